fp_carpma_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative FP multiplier (fp_carpma) between N_REQ requesters.
- Grants one request at a time and drives the multiplier's en_i/x1_i/x2_i for a fixed MUL_LAT-cycle window.
- Captures the multiplier's sonuc_o and returns it to the granted requester with a one-cycle done pulse.
- Sits between the FP-consumer blocks and the single fp_carpma instance; the top level ties the multiplier's rst_i to ~rst_ni.

---
 rtl/fp_carpma_arb.sv | 111 +++++++++++
 tb/tb_fp_carpma_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_carpma_arb.sv
// fp_carpma_arb: round-robin arbiter sharing one iterative FP multiplier.
// Holds en for MUL_LAT cycles, captures the product and pulses done.
module fp_carpma_arb #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 76,
  parameter int IDW     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [32*N_REQ-1:0]  a_i,
  input  logic [32*N_REQ-1:0]  b_i,
  output logic [N_REQ-1:0]     ack_o,
  output logic [N_REQ-1:0]     done_o,
  output logic [31:0]          sonuc_o,
  output logic [IDW-1:0]       done_id_o,
  output logic                 busy_o,
  output logic                 mul_en_o,
  output logic [31:0]          mul_x1_o,
  output logic [31:0]          mul_x2_o,
  input  logic [31:0]          mul_sonuc_i
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  win;
  logic            hit;
  logic [CW-1:0]   cnt;

  // first requester at or after rr_ptr, wrapping at N_REQ-1
  always_comb begin
    int k;
    hit = 1'b0;
    win = '0;
    k   = int'(rr_ptr);
    for (int i = 0; i < N_REQ; i++) begin
      if (!hit && req_i[k]) begin
        hit = 1'b1;
        win = IDW'(k);
      end
      if (k == N_REQ - 1) k = 0;
      else k = k + 1;
    end
  end

  // grant pulse only while idle and out of reset
  always_comb begin
    ack_o = '0;
    if (state == IDLE && hit && rst_ni)
      ack_o[win] = 1'b1;
  end

  // sequencer: grant, hold multiplier enable, capture, report
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      cnt       <= '0;
      done_o    <= '0;
      sonuc_o   <= '0;
      done_id_o <= '0;
      busy_o    <= 1'b0;
      mul_en_o  <= 1'b0;
      mul_x1_o  <= '0;
      mul_x2_o  <= '0;
    end else begin
      done_o <= '0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            mul_x1_o <= a_i[32*int'(win) +: 32];
            mul_x2_o <= b_i[32*int'(win) +: 32];
            grant_id <= win;
            rr_ptr   <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
            cnt      <= '0;
            mul_en_o <= 1'b1;
            busy_o   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(MUL_LAT - 1)) begin
            sonuc_o          <= mul_sonuc_i;
            done_id_o        <= grant_id;
            done_o[grant_id] <= 1'b1;
            mul_en_o         <= 1'b0;
            state            <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_carpma_arb.sv
// tb_fp_carpma_arb: random and directed checks of fp_carpma_arb
// against a timeline model, with a behavioural multiplier stand-in.
module tb_fp_carpma_arb;

  localparam int N   = 4;
  localparam int L   = 76;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [32*N-1:0]   a = '0;
  logic [32*N-1:0]   b = '0;
  logic [N-1:0]      ack, done;
  logic [31:0]       sonuc, mx1, mx2;
  logic [31:0]       msonuc = 32'hDEADBEEF;
  logic [IDW-1:0]    did;
  logic              busy, men;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fp_carpma_arb #(.N_REQ(N), .MUL_LAT(L), .IDW(IDW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .a_i(a), .b_i(b),
    .ack_o(ack), .done_o(done), .sonuc_o(sonuc), .done_id_o(did),
    .busy_o(busy), .mul_en_o(men), .mul_x1_o(mx1), .mul_x2_o(mx2),
    .mul_sonuc_i(msonuc)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    int e;
    logic [47:0] m;
    logic [22:0] f;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    m = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e++;
    end else begin
      f = m[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], f};
  endfunction

  // multiplier stand-in: product valid only after 60 enabled cycles
  int mcnt = 0;
  always @(posedge clk) begin
    if (!men) begin
      mcnt   <= 0;
      msonuc <= 32'hDEADBEEF;
    end else begin
      mcnt   <= mcnt + 1;
      msonuc <= (mcnt >= 59) ? fmul(mx1, mx2) : 32'hDEADBEEF;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // model: age = cycles since ack (-1 idle), round-robin pointer
  int          age = -1;
  int          ptr = 0;
  int          gid = 0;
  int          didm = 0;
  logic [31:0] x1m = '0, x2m = '0, sm = '0;
  bit          mvalid = 0;
  logic [N-1:0] ack_seen = '0;

  always @(negedge clk) begin
    int w;
    logic [N-1:0] eack, edone;
    ack_seen = ack;
    if (mvalid) begin
      w = pick(req, ptr);
      eack = '0;
      if (age < 0 && rst_n && w >= 0) eack = N'(1) << w;
      edone = (age == L + 1) ? (N'(1) << gid) : '0;
      chk("ack", 32'(ack), 32'(eack));
      chk("done", 32'(done), 32'(edone));
      chk("busy", 32'(busy), 32'(age >= 1));
      chk("mul_en", 32'(men), 32'(age >= 1 && age <= L));
      chk("sonuc", sonuc, sm);
      chk("done_id", 32'(did), 32'(didm));
      if (age >= 1 && age <= L) begin
        chk("mul_x1", mx1, x1m);
        chk("mul_x2", mx2, x2m);
      end
    end
    if (!rst_n) begin
      age = -1; ptr = 0; gid = 0; didm = 0;
      x1m = '0; x2m = '0; sm = '0;
      mvalid = 1;
    end else if (mvalid) begin
      if (age < 0) begin
        w = pick(req, ptr);
        if (w >= 0) begin
          x1m = a[32*w +: 32];
          x2m = b[32*w +: 32];
          gid = w;
          ptr = (w + 1) % N;
          age = 1;
        end
      end else if (age <= L) begin
        age++;
        if (age == L + 1) begin
          sm = fmul(x1m, x2m);
          didm = gid;
        end
      end else begin
        age = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] x, input logic [31:0] y);
    a[32*k +: 32] = x;
    b[32*k +: 32] = y;
  endtask

  task automatic wait_ack(output int id, output int t);
    id = -1;
    t = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        t = cyc;
        for (int k = 0; k < N; k++) if (ack[k]) id = k;
        break;
      end
    end
    if (id < 0) begin
      vectors++;
      errs++;
      $display("FAIL ack_timeout: no ack within 300 cycles, req=%b", req);
    end
  endtask

  task automatic wait_done(output int id, output int t, output int en_cnt);
    id = -1;
    t = 0;
    en_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (men) en_cnt++;
      if (done != '0) begin
        t = cyc;
        for (int k = 0; k < N; k++) if (done[k]) id = k;
        break;
      end
    end
    if (id < 0) begin
      vectors++;
      errs++;
      $display("FAIL done_timeout: no done within 300 cycles");
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    int id, t, t0, tprev, n;
    logic [31:0] exp_r [4];

    // reset and idle
    rst_n = 1'b0;
    req = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_en", 32'(men), 32'd0);
    chk("rst_sonuc", sonuc, 32'd0);
    chk("rst_done_id", 32'(did), 32'd0);
    chk("rst_x1", mx1, 32'd0);
    repeat (3) tick();

    // single operation on requester 1
    set_op(1, 32'h40000000, 32'h40400000);
    req = 4'b0010;
    wait_ack(id, t0);
    chk("single_ack", 32'(ack), 32'h2);
    tick();
    req[1] = 1'b0;
    wait_done(id, t, n);
    chk("single_done", 32'(done), 32'h2);
    chk("single_sonuc", sonuc, 32'h40C00000);
    chk("single_done_id", 32'(did), 32'd1);
    chk("single_en_len", 32'(n), 32'd76);
    chk("single_latency", 32'(t - t0), 32'd77);

    // reset pointer, then four-way contention
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(0, 32'h3FC00000, 32'h3FC00000);
    set_op(1, 32'hC0000000, 32'h3F000000);
    set_op(2, 32'h40000000, 32'h40400000);
    set_op(3, 32'h3F800000, 32'h3F800000);
    exp_r[0] = 32'h40100000;
    exp_r[1] = 32'hBF800000;
    exp_r[2] = 32'h40C00000;
    exp_r[3] = 32'h3F800000;
    req = 4'hF;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(id, t);
      chk("cont_order", 32'(id), 32'(i));
      if (i > 0) chk("cont_spacing", 32'(t - tprev), 32'd78);
      tprev = t;
      tick();
      if (id >= 0) req[id] = 1'b0;
      wait_done(id, t, n);
      chk("cont_result", sonuc, exp_r[i]);
    end

    // wrap after r3: r0 then r3
    req = 4'b1001;
    wait_ack(id, t);
    chk("wrap_first", 32'(id), 32'd0);
    tick();
    req[0] = 1'b0;
    wait_done(id, t, n);
    wait_ack(id, t);
    chk("wrap_second", 32'(id), 32'd3);
    tick();
    req[3] = 1'b0;
    wait_done(id, t, n);

    // late request and operand change during RUN
    set_op(0, 32'h3FC00000, 32'h40000000);
    req = 4'b0001;
    wait_ack(id, t0);
    chk("late_first", 32'(id), 32'd0);
    tick();
    req[0] = 1'b0;
    repeat (5) tick();
    set_op(2, 32'h40400000, 32'h40400000);
    req[2] = 1'b1;
    a[31:0] = 32'h41000000;
    wait_done(id, t, n);
    chk("late_sonuc", sonuc, 32'h40400000);
    chk("late_done_id", 32'(did), 32'd0);
    wait_ack(id, t);
    chk("late_second", 32'(id), 32'd2);
    chk("late_spacing", 32'(t - t0), 32'd78);
    tick();
    req[2] = 1'b0;
    wait_done(id, t, n);
    chk("late_sonuc2", sonuc, 32'h41100000);

    // reset in the middle of RUN
    req = 4'b0010;
    wait_ack(id, t);
    chk("midrst_ack", 32'(id), 32'd1);
    tick();
    req = 4'b1001;
    repeat (29) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_mul_en", 32'(men), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_regrant", 32'(ack), 32'h1);
    tick();
    req[0] = 1'b0;
    wait_done(id, t, n);
    chk("midrst_sonuc", sonuc, 32'h41800000);
    wait_ack(id, t);
    chk("midrst_next", 32'(id), 32'd3);
    tick();
    req[3] = 1'b0;
    wait_done(id, t, n);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (ack_seen[k]) req[k] = 1'b0;
        else if (!req[k]) begin
          if ($urandom_range(0, 3) == 0) req[k] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) set_op(k, rnd_fp(), rnd_fp());
      end
    end
    tick();
    req = '0;
    repeat (200) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
